// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int unsigned ITERS   = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_e;

    typedef enum logic {
        OP_MUL,
        OP_DIV
    } op_e;

endpackage

// File: rtl/multdiv_step.sv
// One combinational iteration shared by multiply (shift-add, LSB first)
// and restoring divide (shift-subtract, quotient shifted in at bit 0).
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = ITERS
) (
    input  op_e                  op_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     mag_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic                 qbit_o
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   diff;

    always_comb begin
        addend = acc_i[0] ? mag_i : '0;
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        rem    = acc_i[2*WIDTH-1:WIDTH-1];
        diff   = rem - {1'b0, mag_i};
        acc_o  = '0;
        qbit_o = 1'b0;
        if (op_i == OP_MUL) begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end else begin
            // diff[WIDTH] set means the trial subtraction borrowed: restore
            qbit_o = ~diff[WIDTH];
            acc_o  = {(qbit_o ? diff[WIDTH-1:0] : rem[WIDTH-1:0]),
                      acc_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the iterative signed multiply/divide unit.
// Optional MULTDIV_EARLY_DONE_EN: trivially-known results skip the iterations.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = ITERS,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_e             state_q;
    op_e                op_q;
    logic               neg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mag_q;
    logic [WIDTH-1:0]   result_q;
    logic               exc_q;
    logic               rdy_q;
    logic               busy_q;

    logic               start;
    op_e                start_op;
    logic               start_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] step_acc;
    logic               step_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   result_d;
    logic               exc_d;
    logic               early;
    logic               early_exc;

    multdiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op_i   (op_q),
        .acc_i  (acc_q),
        .mag_i  (mag_q),
        .acc_o  (step_acc),
        .qbit_o (step_q)
    );

    always_comb begin
        start     = ctrl_MULT | ctrl_DIV;
        start_op  = ctrl_MULT ? OP_MUL : OP_DIV;
        start_neg = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        // Unsigned negate: INT_MIN maps to itself, which is its true magnitude
        a_mag     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_mag     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    end

    always_comb begin
        acc_d    = step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
        prod     = neg_q ? -acc_d : acc_d;
        quo      = acc_d[WIDTH-1:0];
        result_d = '0;
        exc_d    = 1'b0;
        if (op_q == OP_MUL) begin
            result_d = prod[WIDTH-1:0];
            exc_d    = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
        end else if (mag_q == '0) begin
            result_d = '0;
            exc_d    = 1'b1;
        end else begin
            result_d = neg_q ? -quo : quo;
            // A positive quotient with the top bit set only arises from INT_MIN / -1
            exc_d    = ~neg_q & quo[WIDTH-1];
        end
    end

`ifdef MULTDIV_EARLY_DONE_EN
    always_comb begin
        early     = start & ((data_operandA == '0) | (data_operandB == '0));
        early_exc = ~ctrl_MULT & ctrl_DIV & (data_operandB == '0);
    end
`else
    always_comb begin
        early     = 1'b0;
        early_exc = 1'b0;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mag_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (start) begin
                op_q   <= start_op;
                neg_q  <= start_neg;
                cnt_q  <= '0;
                mag_q  <= b_mag;
                acc_q  <= {{WIDTH{1'b0}}, a_mag};
                busy_q <= 1'b1;
                if (early) begin
                    state_q  <= DONE;
                    result_q <= '0;
                    exc_q    <= early_exc;
                    rdy_q    <= 1'b1;
                end else begin
                    state_q <= (start_op == OP_MUL) ? MUL : DIV;
                end
            end else begin
                unique case (state_q)
                    MUL, DIV: begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_STEP) begin
                            state_q  <= DONE;
                            result_q <= result_d;
                            exc_q    <= exc_d;
                            rdy_q    <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl; expected latency follows MULTDIV_EARLY_DONE_EN.
module tb_multdiv_ctrl;
    import multdiv_pkg::*;

    localparam int unsigned W   = 32;
    localparam int          LAT = 33;

    logic         clock = 1'b0;
    logic         reset;
    logic         ctrl_MULT;
    logic         ctrl_DIV;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    typedef struct {
        logic [W-1:0] res;
        logic         exc;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] last_res = '0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    multdiv_ctrl #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model(input bit mul, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] res, output logic exc);
        logic signed [2*W-1:0] p;
        logic [W-1:0]          all_ones;
        all_ones = '1;
        if (mul) begin
            p   = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
            res = p[W-1:0];
            exc = (p[2*W-1:W] != {W{p[W-1]}});
        end else if (b == '0) begin
            res = '0;
            exc = 1'b1;
        end else if (a == INT_MIN && b == all_ones) begin
            res = INT_MIN;
            exc = 1'b1;
        end else begin
            res = $signed(a) / $signed(b);
            exc = 1'b0;
        end
    endfunction

    function automatic bit trivial(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULTDIV_EARLY_DONE_EN
        return (a == '0) || (b == '0);
`else
        return (a == b) && (a !== a);
`endif
    endfunction

    // Start pulse in the cycle after the next edge; any pending op is aborted.
    task automatic drive_op(input bit mul, input bit div, input logic [W-1:0] a,
                            input logic [W-1:0] b, output int t0);
        exp_t e;
        @(posedge clock); #1;
        t0            = cyc;
        ctrl_MULT     = mul;
        ctrl_DIV      = div;
        data_operandA = a;
        data_operandB = b;
        model(mul, a, b, e.res, e.exc);
        e.cyc = t0 + (trivial(a, b) ? 1 : LAT);
        sb.delete();
        sb.push_back(e);
        @(posedge clock); #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        if (n >= 200) begin
            check_eq("rdy_timeout", W'(sb.size()), '0);
            sb.delete();
        end
    endtask

    task automatic run_op(input bit mul, input bit div, input logic [W-1:0] a, input logic [W-1:0] b);
        int t0;
        drive_op(mul, div, a, b, t0);
        wait_done();
    endtask

    always @(negedge clock) begin
        if (data_resultRDY) begin
            if (sb.size() == 0) begin
                check_eq("rdy_without_op", W'(sb.size()), W'(1));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("result", data_result, e.res);
                check_eq("exception", W'(data_exception), W'(e.exc));
                check_eq("rdy_cycle", W'(cyc), W'(e.cyc));
                last_res = e.res;
            end
        end
    end

    initial begin
        int t0;
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("reset_result", data_result, '0);
        check_eq("reset_exc", W'(data_exception), '0);
        check_eq("reset_rdy", W'(data_resultRDY), '0);
        check_eq("reset_busy", W'(busy), '0);
        reset = 1'b0;

        drive_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, t0);
        check_eq("busy_t1", W'(busy), W'(1));
        while (cyc < t0 + LAT) begin
            @(posedge clock); #1;
        end
        check_eq("busy_t33", W'(busy), W'(1));
        @(posedge clock); #1;
        check_eq("busy_t34", W'(busy), '0);
        wait_done();
        repeat (5) @(posedge clock);
        #1;
        check_eq("hold_result", data_result, last_res);

        run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
        run_op(1'b0, 1'b1, 32'd5, 32'd0);
        run_op(1'b0, 1'b1, INT_MIN, 32'hFFFF_FFFF);
        run_op(1'b1, 1'b0, 32'd0, 32'd9);
        run_op(1'b1, 1'b1, 32'd3, 32'd5);
        run_op(1'b0, 1'b1, INT_MIN, 32'd1);
        run_op(1'b1, 1'b0, INT_MIN, 32'hFFFF_FFFF);
        run_op(1'b0, 1'b1, 32'd0, 32'd7);
        run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
        for (int i = 0; i < 8; i++) begin
            bit m;
            m = bit'($urandom_range(1));
            run_op(m, ~m, $urandom, (i == 3) ? 32'd3 : $urandom);
        end

        drive_op(1'b1, 1'b0, 32'd3, 32'd4, t0);
        repeat (8) begin
            @(posedge clock); #1;
        end
        drive_op(1'b0, 1'b1, 32'd100, 32'd3, t0);
        wait_done();
        check_eq("abort_result", last_res, 32'd33);

        drive_op(1'b1, 1'b0, 32'h0000_1234, 32'h0000_5678, t0);
        repeat (3) begin
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        check_eq("rst_mid_busy", W'(busy), '0);
        check_eq("rst_mid_result", data_result, '0);
        check_eq("rst_mid_exc", W'(data_exception), '0);
        check_eq("rst_mid_rdy", W'(data_resultRDY), '0);
        repeat (40) @(posedge clock);
        #1;
        check_eq("rst_idle_busy", W'(busy), '0);
        check_eq("rst_idle_result", data_result, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
